// File: rtl/joy_pkg.sv
// Shared types and helpers for the joystick direction filter.
// Direction vectors are packed {up, down, left, right}.
package joy_pkg;

  localparam int unsigned DIR_W = 4;
  localparam int unsigned UP    = 3;
  localparam int unsigned DOWN  = 2;
  localparam int unsigned LEFT  = 1;
  localparam int unsigned RIGHT = 0;

  typedef logic [DIR_W-1:0] dir_t;

  typedef enum logic [1:0] {
    PASS       = 2'd0,
    FOUR_LAST  = 2'd1,
    FOUR_FIRST = 2'd2,
    TWO_H      = 2'd3
  } joy_mode_e;

  typedef enum logic [1:0] {
    ROT_NONE = 2'd0,
    ROT_CW   = 2'd1,
    ROT_CCW  = 2'd2,
    ROT_180  = 2'd3
  } joy_rot_e;

  // One-hot of the highest-priority set bit: up > down > left > right.
  function automatic dir_t pick_dir(input dir_t v);
    dir_t o;
    o = '0;
    if (v[UP])         o[UP]    = 1'b1;
    else if (v[DOWN])  o[DOWN]  = 1'b1;
    else if (v[LEFT])  o[LEFT]  = 1'b1;
    else if (v[RIGHT]) o[RIGHT] = 1'b1;
    return o;
  endfunction

  function automatic dir_t rotate_dir(input dir_t v, input joy_rot_e r);
    dir_t o;
    case (r)
      ROT_CW:  o = {v[RIGHT], v[LEFT],  v[UP],    v[DOWN]};
      ROT_CCW: o = {v[LEFT],  v[RIGHT], v[DOWN],  v[UP]};
      ROT_180: o = {v[DOWN],  v[UP],    v[RIGHT], v[LEFT]};
      default: o = v;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/joy_dir_filter_lane.sv
// One player lane: rotate, optional per-bit debounce, movement-mode arbitration.
// Mode is the registered copy from the top; mode_chg flags the edge it is updated.
module joy_dir_lane
  import joy_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 0
) (
  input  logic      clk_sys,
  input  logic      reset,
  input  joy_mode_e mode,
  input  logic      mode_chg,
  input  joy_rot_e  rot,
  input  dir_t      joy_in,
  output dir_t      joy_out,
  output logic      dir_chg
);

  localparam dir_t H_MASK = 4'b0011;

  dir_t in_q, in_d;
  dir_t stable;
  dir_t prev_stable_q, prev_stable_d;
  dir_t mask_q, mask_d;
  dir_t sel_q, sel_d;
  dir_t joy_out_q, joy_out_d;
  dir_t prev_out_q, prev_out_d;
  logic dir_chg_q, dir_chg_d;
  dir_t new_c, horiz_c, new_h_c;

  assign in_d = rotate_dir(joy_in, rot);

  if (DEBOUNCE == 0) begin : g_nodeb
    assign stable = in_q;
  end else begin : g_deb
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

    dir_t             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [DIR_W];
    logic [CNT_W-1:0] cnt_d [DIR_W];

    // Count consecutive edges where the sample disagrees; flip on the last one.
    always_comb begin
      stable_d = stable_q;
      for (int unsigned b = 0; b < DIR_W; b++) begin
        cnt_d[b] = '0;
        if (in_q[b] != stable_q[b]) begin
          if (cnt_q[b] == CNT_W'(DEBOUNCE - 1)) stable_d[b] = in_q[b];
          else                                  cnt_d[b]    = cnt_q[b] + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        stable_q <= '0;
        for (int unsigned b = 0; b < DIR_W; b++) cnt_q[b] <= '0;
      end else begin
        stable_q <= stable_d;
        for (int unsigned b = 0; b < DIR_W; b++) cnt_q[b] <= cnt_d[b];
      end
    end

    assign stable = stable_q;
  end

  // Arbitration; on a mode change the output holds while mask/selection reset.
  always_comb begin
    new_c         = stable & ~prev_stable_q;
    horiz_c       = stable & H_MASK;
    new_h_c       = new_c & H_MASK;
    prev_stable_d = stable;
    prev_out_d    = joy_out_q;
    mask_d        = mask_q;
    sel_d         = sel_q;
    joy_out_d     = joy_out_q;
    dir_chg_d     = |(joy_out_q ^ prev_out_q);
    if (mode_chg) begin
      mask_d = '1;
      sel_d  = '0;
    end else begin
      case (mode)
        PASS: joy_out_d = stable;
        FOUR_LAST: begin
          joy_out_d = pick_dir(stable & mask_q);
          if (|new_c)                    mask_d = pick_dir(new_c);
          else if (~|(stable & mask_q))  mask_d = '1;
        end
        FOUR_FIRST: begin
          if (~|(stable & sel_q)) sel_d = pick_dir(stable);
          joy_out_d = sel_d;
        end
        TWO_H: begin
          joy_out_d = pick_dir(horiz_c & mask_q);
          if (|new_h_c)                   mask_d = pick_dir(new_h_c);
          else if (~|(horiz_c & mask_q))  mask_d = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      in_q          <= '0;
      prev_stable_q <= '0;
      mask_q        <= '1;
      sel_q         <= '0;
      joy_out_q     <= '0;
      prev_out_q    <= '0;
      dir_chg_q     <= 1'b0;
    end else begin
      in_q          <= in_d;
      prev_stable_q <= prev_stable_d;
      mask_q        <= mask_d;
      sel_q         <= sel_d;
      joy_out_q     <= joy_out_d;
      prev_out_q    <= prev_out_d;
      dir_chg_q     <= dir_chg_d;
    end
  end

  assign joy_out = joy_out_q;
  assign dir_chg = dir_chg_q;

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-player joystick direction filter: registers the shared mode, detects
// mode changes and fans out one independent lane per player.
module joy_dir_filter
  import joy_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned DEBOUNCE    = 0
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [1:0]                   mode,
  input  logic [1:0]                   rot,
  input  logic [DIR_W*NUM_PLAYERS-1:0] joy_in,
  output logic [DIR_W*NUM_PLAYERS-1:0] joy_out,
  output logic [NUM_PLAYERS-1:0]       dir_chg
);

  joy_mode_e mode_q, mode_d;
  logic      mode_chg_c;
  joy_rot_e  rot_c;

  always_comb begin
    mode_d     = joy_mode_e'(mode);
    mode_chg_c = (mode_d != mode_q);
    rot_c      = joy_rot_e'(rot);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) mode_q <= PASS;
    else       mode_q <= mode_d;
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
    joy_dir_lane #(
      .DEBOUNCE(DEBOUNCE)
    ) u_lane (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .mode     (mode_q),
      .mode_chg (mode_chg_c),
      .rot      (rot_c),
      .joy_in   (joy_in[DIR_W*p +: DIR_W]),
      .joy_out  (joy_out[DIR_W*p +: DIR_W]),
      .dir_chg  (dir_chg[p])
    );
  end

endmodule

// File: doc/joy_dir_filter.md
# joy_dir_filter

Parametrised multi-player digital joystick direction filter between the hps_io/keyboard button merge and the arcade core's direction inputs. Per player it remaps for screen rotation, optionally debounces, and restricts output to a selectable movement mode: pass-through, 4-way last-pressed, 4-way first-held, or 2-way horizontal. It supersedes the fixed 4-way single-direction filter for cores with N players and runtime orientation/mode options.

## Interface
- NUM_PLAYERS, 2, number of independent lanes (1..4)
- DEBOUNCE, 0, consecutive differing cycles required before a bit's stable state flips; 0 = no debounce
- clk_sys  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- mode  input  2  0 PASS, 1 FOUR_LAST, 2 FOUR_FIRST, 3 TWO_H; shared by all lanes
- rot  input  2  0 none, 1 CW, 2 CCW, 3 180; shared by all lanes
- joy_in  input  4*NUM_PLAYERS  raw active-high directions; lane p at [4p+3:4p] = {up,down,left,right}
- joy_out  output  4*NUM_PLAYERS  filtered directions, same packing, registered
- dir_chg  output  NUM_PLAYERS  one-cycle pulse when lane p's joy_out changes

## Operation
- Reset: in_q, stable, stable_d, counters, joy_out, dir_chg = 0; mask = 4'b1111.
- Rotate (combinational, before in_q), bits {up,down,left,right} taken from: none {U,D,L,R}; CW {R,L,U,D}; CCW {L,R,D,U}; 180 {D,U,R,L}.
- Debounce, per bit: DEBOUNCE=0 → stable = in_q. Otherwise a counter of width $clog2(DEBOUNCE+1) increments on each edge where in_q != stable, clears when equal; on the DEBOUNCE-th consecutive differing edge, stable flips and the counter clears.
- new = stable & ~stable_d (one-cycle press edge). Priority order for ties: up > down > left > right.
- PASS: joy_out = stable.
- FOUR_LAST: any new bit loads mask with its one-hot (highest-priority new bit if several). If (stable & mask) == 0, mask <= 1111. joy_out = highest-priority bit of stable & mask (always one-hot or zero).
- FOUR_FIRST: if current output bit still held, keep it; new presses ignored. On release, switch to highest-priority held bit, else 0.
- TWO_H: up/down forced 0; left/right arbitrated as FOUR_LAST restricted to bits [1:0].
- Any change of mode: every lane's mask <= 1111 and FOUR_FIRST held selection cleared that edge; joy_out recomputed under the new mode next edge.
- rot change is a plain remap; resulting edges are treated as ordinary presses.
- dir_chg[p] = 1 on the edge after joy_out lane p changed value.

## Timing
- joy_in change before edge 1 → in_q at edge 1.
- DEBOUNCE=0: joy_out updated at edge 2 (2-cycle latency). DEBOUNCE=D: stable at edge D+1, joy_out at edge D+2.
- Glitch shorter than D cycles never reaches stable.
- dir_chg asserts one cycle after the joy_out update, for exactly one cycle.
- Reset mid-operation clears all state immediately (async); first valid output 2 edges after deassertion.
- Lanes fully independent; no cross-lane interaction.

## Structure
- Package joy_pkg: mode enum (PASS, FOUR_LAST, FOUR_FIRST, TWO_H), rotation enum (ROT_NONE, ROT_CW, ROT_CCW, ROT_180), bit index localparams (UP=3, DOWN=2, LEFT=1, RIGHT=0), priority-pick function.
- Sub-module joy_dir_lane (rotate, debounce, arbitration for one player), instanced NUM_PLAYERS times by generate; top handles packing and mode-change detect.

## Test plan
- Reset, DEBOUNCE=0, PASS, rot=0: joy_in lane0 = 1010 → joy_out lane0 = 1010 at edge 2, dir_chg[0] at edge 3.
- FOUR_LAST: hold right (0001), then add up (1001) → out 0001 then 1000; release up → 0001 within 2 cycles via mask reset; simultaneous up+left press from idle → 1000.
- FOUR_FIRST: hold left, add up → stays 0010; release left with up held → 1000.
- TWO_H: raw 1100 → 0000; raw 0011 pressed right then left → 0010.
- rot=CCW, PASS: raw up (1000) → out 0001 (right); rot=CW raw up → 0010.
- DEBOUNCE=4: 3-cycle pulse on right → no output change; 4-cycle hold → out at edge 6; async reset asserted mid-hold → joy_out 0000 immediately, no dir_chg.
